// File: rtl/gencon_defs.sv
// gencon shared definitions: controller state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package gencon_defs;

  typedef enum logic [2:0] {
    SEND_MULT_OP1_START = 3'd0,
    MULT_OP1            = 3'd1,
    SEND_MULT_OP2_START = 3'd2,
    MULT_OP2            = 3'd3,
    SEND_MULT_RES_START = 3'd4,
    MULT_RES            = 3'd5,
    RESULT              = 3'd6
  } state_t;

endpackage

// File: rtl/gencon.sv
// gencon: keypad calculator controller (add/sub/mul, mod 2^WIDTH) with one shared shift-add multiplier.
// Latency: a digit takes 16 cycles to fold in; add/sub results 1 cycle after equals, multiply 18 cycles.
// Backpressure: none; digit strobes are only taken in the START states, others are dropped.
//
// Ports:
//   clk, nRST          - clock (rising edge) and asynchronous active-low reset
//   keypad_input[3:0]  - decimal digit, sampled when read_input is high (values >9 ignored)
//   read_input         - digit strobe
//   operator_input[2:0]- one-hot operator level: 001 add, 010 sub, 100 mul
//   equal_input        - equals level
//   complete           - high once the result is shown
//   display_output     - registered sign-magnitude view of the current operand/result
//   tb_current_state   - current FSM state for debug
module gencon
  import gencon_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             complete,
  output logic [WIDTH-1:0] display_output,
  output state_t           tb_current_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] op1_q,     op1_d;
  logic [WIDTH-1:0] op2_q,     op2_d;
  logic [2:0]       oper_q,    oper_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [3:0]       digit_q,   digit_d;
  logic [WIDTH-1:0] mul_a_q,   mul_a_d;
  logic [WIDTH-1:0] mul_b_q,   mul_b_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             complete_q, complete_d;
  logic [WIDTH-1:0] display_q, display_d;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] digit_ext;
  logic [WIDTH-1:0] show_val;
  logic             digit_ok;
  logic             last_step;

  // Sign-magnitude: magnitude is |v| truncated to WIDTH-1 bits, so the most
  // negative value shows as sign=1, magnitude=0.
  function automatic logic [WIDTH-1:0] sign_mag(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] low;
    low = v[WIDTH-1] ? (~v[WIDTH-2:0] + {{(WIDTH-2){1'b0}}, 1'b1}) : v[WIDTH-2:0];
    return {v[WIDTH-1], low};
  endfunction

  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    oper_d     = oper_q;
    result_d   = result_q;
    digit_d    = digit_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;

    digit_ok   = read_input && (keypad_input <= 4'd9);
    digit_ext  = {{(WIDTH-4){1'b0}}, digit_q};
    step_acc   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
    last_step  = (cnt_q == CW'(WIDTH-1));

    // All three multiply states advance the shared shift-add datapath.
    if (state_q == MULT_OP1 || state_q == MULT_OP2 || state_q == MULT_RES) begin
      acc_d   = step_acc;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end

    case (state_q)
      SEND_MULT_OP1_START: begin
        if (digit_ok) begin
          digit_d = keypad_input;
          mul_a_d = op1_q;
          mul_b_d = WIDTH'(10);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MULT_OP1;
        end else if (!read_input && $onehot(operator_input)) begin
          oper_d  = operator_input;
          state_d = SEND_MULT_OP2_START;
        end
      end

      MULT_OP1: begin
        if (last_step) begin
          op1_d   = step_acc + digit_ext;
          state_d = SEND_MULT_OP1_START;
        end
      end

      SEND_MULT_OP2_START: begin
        if (digit_ok) begin
          digit_d = keypad_input;
          mul_a_d = op2_q;
          mul_b_d = WIDTH'(10);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MULT_OP2;
        end else if (equal_input) begin
          case (oper_q)
            OP_ADD: begin
              result_d = op1_q + op2_q;
              state_d  = RESULT;
            end
            OP_SUB: begin
              result_d = op1_q - op2_q;
              state_d  = RESULT;
            end
            OP_MUL: begin
              mul_a_d  = op1_q;
              mul_b_d  = op2_q;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = SEND_MULT_RES_START;
            end
            default: state_d = state_q;
          endcase
        end
      end

      MULT_OP2: begin
        if (last_step) begin
          op2_d   = step_acc + digit_ext;
          state_d = SEND_MULT_OP2_START;
        end
      end

      SEND_MULT_RES_START: state_d = MULT_RES;

      MULT_RES: begin
        if (last_step) begin
          result_d = step_acc;
          state_d  = RESULT;
        end
      end

      RESULT:  state_d = RESULT;

      default: state_d = SEND_MULT_OP1_START;
    endcase

    // Display and completion follow the next state so they line up with it.
    case (state_d)
      SEND_MULT_OP1_START, MULT_OP1: show_val = op1_d;
      RESULT:                        show_val = result_d;
      default:                       show_val = op2_d;
    endcase
    display_d  = sign_mag(show_val);
    complete_d = (state_d == RESULT);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= SEND_MULT_OP1_START;
      op1_q      <= '0;
      op2_q      <= '0;
      oper_q     <= '0;
      result_q   <= '0;
      digit_q    <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      complete_q <= 1'b0;
      display_q  <= '0;
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      oper_q     <= oper_d;
      result_q   <= result_d;
      digit_q    <= digit_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
      display_q  <= display_d;
    end
  end

  assign complete         = complete_q;
  assign display_output   = display_q;
  assign tb_current_state = state_q;

endmodule

// File: tb/tb_gencon.sv
// tb_gencon: self-checking bench for the gencon calculator controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_gencon;
  import gencon_defs::*;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  state_t      st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gencon #(.WIDTH(16)) dut (
    .clk              (clk),
    .nRST             (nRST),
    .keypad_input     (keypad_input),
    .read_input       (read_input),
    .operator_input   (operator_input),
    .equal_input      (equal_input),
    .complete         (complete),
    .display_output   (display_output),
    .tb_current_state (st)
  );

  // Digits are stored left-to-right as entered: with n digits, the first one
  // keyed is nibble n-1 (so 20'h00128 with n=3 means keys 1,2,8).
  typedef struct packed {
    logic [19:0] a;
    logic [2:0]  an;
    logic [2:0]  op;
    logic [19:0] b;
    logic [2:0]  bn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the design", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int operand(input logic [19:0] d, input logic [2:0] n);
    int v = 0;
    for (int i = 0; i < int'(n); i++) begin
      int k = int'(n) - 1 - i;
      v = (v * 10 + int'(d[k*4 +: 4])) % 65536;
    end
    return v;
  endfunction

  function automatic logic [15:0] model(input vec_t v);
    longint x, y, r;
    int     m;
    logic [15:0] rv;
    logic [16:0] mg;
    x = operand(v.a, v.an);
    y = operand(v.b, v.bn);
    case (v.op)
      3'b001:  r = (x + y) % 65536;
      3'b010:  r = (x - y + 65536) % 65536;
      default: r = (x * y) % 65536;
    endcase
    rv = 16'(r);
    m  = (r >= 32768) ? int'(65536 - r) : int'(r);
    mg = 17'(m);
    return {rv[15], mg[14:0]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    nRST = 1'b0;
    read_input = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    bit ok;
    @(negedge clk);
    keypad_input = d;
    read_input   = 1'b1;
    @(negedge clk);
    read_input   = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (st == SEND_MULT_OP1_START || st == SEND_MULT_OP2_START) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) timeout("digit_return");
  endtask

  task automatic run_calc(input vec_t v, input logic [15:0] exp, input bit rst, input string tag);
    int  n;
    bit  ok;
    if (rst) do_reset();
    for (int i = 0; i < int'(v.an); i++) press(v.a[(int'(v.an)-1-i)*4 +: 4]);
    @(negedge clk);
    operator_input = v.op;
    @(negedge clk);
    for (int i = 0; i < int'(v.bn); i++) press(v.b[(int'(v.bn)-1-i)*4 +: 4]);
    @(negedge clk);
    equal_input = 1'b1;
    if (v.op == 3'b100) begin
      @(negedge clk);
      check({tag, "_resstart"}, 32'(st), 32'(SEND_MULT_RES_START));
      @(negedge clk);
      n = 0;
      while (st == MULT_RES && n < 40) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_mulres_cycles"}, 32'(n), 32'd16);
    end
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (st == RESULT) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) timeout({tag, "_result"});
    check({tag, "_disp"},     32'(display_output), 32'(exp));
    check({tag, "_complete"}, 32'(complete),       32'd1);
    // equals and operator still held: the result must stay put
    repeat (3) @(negedge clk);
    check({tag, "_hold_state"}, 32'(st),             32'(RESULT));
    check({tag, "_hold_disp"},  32'(display_output), 32'(exp));
    equal_input    = 1'b0;
    operator_input = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   n;
    vec_t rv;

    vecs[0] = '{20'h00011, 3'd2, 3'b001, 20'h00023, 3'd2, 16'h0022}; // 11+23
    vecs[1] = '{20'h00005, 3'd1, 3'b010, 20'h00009, 3'd1, 16'h8004}; // 5-9
    vecs[2] = '{20'h00128, 3'd3, 3'b100, 20'h00256, 3'd3, 16'h8000}; // 128*256 wraps
    vecs[3] = '{20'h00000, 3'd0, 3'b001, 20'h00007, 3'd1, 16'h0007}; // no op1 digits
    vecs[4] = '{20'h00006, 3'd1, 3'b100, 20'h00000, 3'd0, 16'h0000}; // no op2 digits
    vecs[5] = '{20'h00003, 3'd1, 3'b010, 20'h00003, 3'd1, 16'h0000}; // 3-3
    vecs[6] = '{20'h99999, 3'd5, 3'b001, 20'h00000, 3'd0, 16'hF961}; // 99999 wraps negative
    vecs[7] = '{20'h00200, 3'd3, 3'b100, 20'h00200, 3'd3, 16'hE3C0}; // 200*200
    vecs[8] = '{20'h00001, 3'd1, 3'b010, 20'h32768, 3'd5, 16'hFFFF}; // 1-32768
    vecs[9] = '{20'h00007, 3'd1, 3'b100, 20'h00009, 3'd1, 16'h003F}; // 7*9

    // reset values
    nRST = 1'b0;
    read_input = 1'b0; keypad_input = '0; operator_input = '0; equal_input = 1'b0;
    #2;
    check("rst_state",    32'(st),             32'(SEND_MULT_OP1_START));
    check("rst_complete", 32'(complete),       32'd0);
    check("rst_disp",     32'(display_output), 32'd0);

    // one digit takes exactly 16 cycles in MULT_OP1
    do_reset();
    @(negedge clk);
    keypad_input = 4'd7;
    read_input   = 1'b1;
    @(negedge clk);
    read_input   = 1'b0;
    n = 0;
    while (st == MULT_OP1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("op1_cycles", 32'(n),              32'd16);
    check("op1_back",   32'(st),             32'(SEND_MULT_OP1_START));
    check("op1_disp",   32'(display_output), 32'h0007);

    // out-of-range key is dropped
    do_reset();
    press(4'd4);
    @(negedge clk);
    keypad_input = 4'd12;
    read_input   = 1'b1;
    @(negedge clk);
    read_input   = 1'b0;
    check("bad_key_state", 32'(st),             32'(SEND_MULT_OP1_START));
    check("bad_key_disp",  32'(display_output), 32'h0004);
    press(4'd3);
    check("bad_key_after", 32'(display_output), 32'd43);

    // reset in the middle of an op2 digit multiply
    do_reset();
    press(4'd1);
    @(negedge clk);
    operator_input = 3'b001;
    @(negedge clk);
    keypad_input = 4'd2;
    read_input   = 1'b1;
    @(negedge clk);
    read_input   = 1'b0;
    check("mid_in_mult", 32'(st), 32'(MULT_OP2));
    repeat (5) @(negedge clk);
    nRST = 1'b0;
    #1;
    check("abort_state",    32'(st),             32'(SEND_MULT_OP1_START));
    check("abort_complete", 32'(complete),       32'd0);
    check("abort_disp",     32'(display_output), 32'd0);
    operator_input = '0;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    rv = '{20'h00002, 3'd1, 3'b001, 20'h00003, 3'd1, 16'h0005};
    run_calc(rv, rv.exp, 1'b0, "rerun");

    // directed table
    for (int i = 0; i < 10; i++) begin
      run_calc(vecs[i], vecs[i].exp, 1'b1, $sformatf("vec%0d", i));
    end

    // random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      rv     = '0;
      rv.an  = 3'($urandom_range(0, 5));
      rv.bn  = 3'($urandom_range(0, 5));
      for (int k = 0; k < 5; k++) begin
        rv.a[k*4 +: 4] = 4'($urandom_range(0, 9));
        rv.b[k*4 +: 4] = 4'($urandom_range(0, 9));
      end
      case ($urandom_range(0, 2))
        0:       rv.op = 3'b001;
        1:       rv.op = 3'b010;
        default: rv.op = 3'b100;
      endcase
      run_calc(rv, model(rv), 1'b1, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gencon.md
Name: gencon

Overview:
- General calculator controller for a 16-bit signed calculator.
- Accepts decimal digit keypresses for two operands, a one-hot operator and an equals press, and computes add, subtract or multiply.
- Drives a 16-bit sign-magnitude display word and a completion flag.
- Digit accumulation (operand×10) and the final multiply share one sequential shift-add multiplier.

Parameters:
- WIDTH, 16, operand/result/display width. Only 16 is required to be supported.

Ports:
- clk  input  1  system clock, rising-edge active.
- nRST  input  1  asynchronous active-low reset.
- keypad_input  input  4  decimal digit 0-9, valid when read_input is sampled high.
- read_input  input  1  digit strobe, sampled on posedge, nominally 1 cycle wide.
- operator_input  input  3  one-hot operator: 001 add, 010 subtract, 100 multiply. Level, may be held.
- equal_input  input  1  equals request. Level, may be held.
- complete  output  1  high while the result is valid.
- display_output  output  16  sign-magnitude: [15] sign, [14:0] magnitude.
- tb_current_state  output  state_t  current FSM state, for debug/verification.

Behaviour:
- Interface: one clock (clk); reset nRST is asynchronous and active-low.
- state_t is a 3-bit enum defined in package file gencon_defs.sv. The package is imported into the module, so state names are visible in module scope. States:
  - SEND_MULT_OP1_START
  - MULT_OP1
  - SEND_MULT_OP2_START
  - MULT_OP2
  - SEND_MULT_RES_START
  - MULT_RES
  - RESULT
- Reset (async, nRST=0): state=SEND_MULT_OP1_START; op1, op2, operator, result, multiplier regs=0; complete=0; display_output=0.
- SEND_MULT_OP1_START, priority order:
  - read_input=1 with keypad_input≤9: latch digit, load multiplier (A=op1, B=10, acc=0, cnt=0), go MULT_OP1.
  - read_input=1 with keypad_input>9: ignored.
  - Else operator_input exactly one-hot: latch operator, go SEND_MULT_OP2_START.
  - Else (including non-one-hot operator values): hold.
- MULT_OP1: one shift-add step per cycle (if B[0] then acc+=A; A<<=1; B>>=1; cnt++). After the 16th step, op1 = acc+digit (mod 2^16) and state returns to SEND_MULT_OP1_START. This is 16 cycles after the sampling edge.
- SEND_MULT_OP2_START, priority order:
  - read_input with valid digit: go MULT_OP2 (same algorithm on op2).
  - Else equal_input=1:
    - add: result=op1+op2, go RESULT next cycle.
    - subtract: result=op1−op2, go RESULT next cycle.
    - multiply: load A=op1, B=op2, go SEND_MULT_RES_START.
  - operator_input is ignored in this state.
- SEND_MULT_RES_START → MULT_RES on the next cycle. MULT_RES runs 16 steps, result=acc low 16 bits, then goes to RESULT.
- RESULT: complete=1. State holds until reset; all inputs are ignored, including a held equal_input or operator_input.
- Arithmetic: operands are unsigned-entered but treated as 16-bit two's complement. Add/sub/mul are mod 2^16 with no overflow flag; multiply keeps the low 16 bits of the product.
- display_output (registered) = sign-magnitude of the current value:
  - SEND_MULT_OP1_START/MULT_OP1: op1.
  - SEND_MULT_OP2_START through MULT_RES: op2.
  - RESULT: result.
  - Conversion: bit15=value[15]; [14:0]=|value| truncated to 15 bits. 0x8000 displays as 1_000000000000000.
- Operator asserted before any digit gives op1=0. Equals with no op2 digits gives op2=0.
- read_input held high: one digit is accepted per return to a START state.
- Reset mid-operation (any state, including during multiply) aborts immediately to the reset values.

Test Plan:
- Reset, digits 1,1, operator 001 held, digits 2,3, equal held → complete=1, display_output=0x0022 (34), state RESULT.
- Digits 5, operator 010, digits 9 → result −4; display_output=0x8004, complete=1.
- Digits 1,2,8, operator 100, digits 2,5,6 → result 32768 wraps to 0x8000; display_output=0x8000. This includes checking MULT_RES lasts 16 cycles.
- Digit timing: read_input pulse with digit 7 in SEND_MULT_OP1_START → state MULT_OP1 for exactly 16 cycles, then back in START; display_output=0x0007.
- keypad_input=12 with read_input → ignored, op1 unchanged, state stays SEND_MULT_OP1_START.
- Assert nRST=0 during MULT_OP2 → immediate SEND_MULT_OP1_START, complete=0, display_output=0. Re-run 2+3 → 0x0005.
